// File: rtl/lizwiz_input_pkg.sv
// Lizwiz input controller: shared scan codes, bit maps and types.
// Imported by the key decoder and the controller top.
package lizwiz_input_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_F3    = 8'h04;
  localparam logic [7:0] SC_REL   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam int IN0_UP    = 0;
  localparam int IN0_LEFT  = 1;
  localparam int IN0_RIGHT = 2;
  localparam int IN0_DOWN  = 3;
  localparam int IN0_COIN  = 5;

  localparam int IN1_J2UP    = 0;
  localparam int IN1_J2LEFT  = 1;
  localparam int IN1_J2RIGHT = 2;
  localparam int IN1_J2DOWN  = 3;
  localparam int IN1_FIRE    = 4;
  localparam int IN1_START1  = 5;
  localparam int IN1_START2  = 6;
  localparam int IN1_J2FIRE  = 7;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_HOLDOFF
  } coin_state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
    logic f1;
    logic f2;
    logic f3;
  } keys_t;

endpackage

// File: rtl/lizwiz_input_ctrl_key_decode.sv
// PS/2 event decoder: tracks held state of the game keys.
// o_keys is the state after this cycle's event (next-state view).
module lizwiz_key_decode
  import lizwiz_input_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [64:0] i_ps2_key,
  output keys_t       o_keys
);

  logic       r_tog;
  keys_t      r_keys;
  keys_t      w_keys;
  logic       w_evt;
  logic       w_press;
  logic       w_ext;
  logic [8:0] w_code;

  assign w_evt = (i_ps2_key[64] != r_tog)
              && (i_ps2_key[63:24] == 40'd0);
  assign w_press = i_ps2_key[15:8] != SC_REL;
  assign w_ext = w_press ? (i_ps2_key[15:8] == SC_EXT)
                         : (i_ps2_key[23:16] == SC_EXT);
  assign w_code = {w_ext, i_ps2_key[7:0]};

  always_comb begin
    w_keys = r_keys;
    if (w_evt) begin
      unique case (1'b1)
        (w_code[7:0] == SC_UP):      w_keys.up    = w_press;
        (w_code[7:0] == SC_DOWN):    w_keys.down  = w_press;
        (w_code[7:0] == SC_LEFT):    w_keys.left  = w_press;
        (w_code[7:0] == SC_RIGHT):   w_keys.right = w_press;
        (w_code == {1'b0, SC_SPACE}),
        (w_code == {1'b0, SC_CTRL}): w_keys.fire  = w_press;
        (w_code == {1'b0, SC_F1}):   w_keys.f1    = w_press;
        (w_code == {1'b0, SC_F2}):   w_keys.f2    = w_press;
        (w_code == {1'b0, SC_F3}):   w_keys.f3    = w_press;
        default:                     w_keys       = r_keys;
      endcase
    end
  end

  // Toggle history follows the input even in reset: no event at release.
  always_ff @(posedge i_clk) begin
    r_tog <= i_ps2_key[64];
    if (i_reset) begin
      r_keys <= '0;
    end else begin
      r_keys <= w_keys;
    end
  end

  assign o_keys = w_keys;

endmodule

// File: rtl/lizwiz_input_ctrl.sv
// Lizwiz input controller: keyboard/joystick merge, coin pulse FSM,
// active-low IN0/IN1 port registers and coin counter.
module lizwiz_input_ctrl
  import lizwiz_input_pkg::*;
#(
  parameter int COIN_FRAMES    = 4,
  parameter int HOLDOFF_FRAMES = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [64:0] PS2_KEY,
  input  logic [15:0] JOY1,
  input  logic [15:0] JOY2,
  input  logic        ROTATE,
  input  logic        VBLANK,
  output logic [7:0]  IN0,
  output logic [7:0]  IN1,
  output logic [7:0]  COIN_COUNT
);

  localparam int MAXF = (COIN_FRAMES > HOLDOFF_FRAMES)
                      ? COIN_FRAMES : HOLDOFF_FRAMES;
  localparam int CW = $clog2(MAXF + 1);

  keys_t         w_keys;
  logic          w_up, w_down, w_left, w_right;
  logic          w_fire, w_start1, w_start2;
  logic          w_src, w_joy_src, w_req, w_frame, w_coin;
  logic [7:0]    w_in0, w_in1;
  logic          r_src, r_vb;
  logic          r_pend, w_pend;
  coin_state_e   r_state, w_state;
  logic [CW-1:0] r_fcnt, w_fcnt;
  logic [7:0]    r_cnt, w_cnt;
  logic [7:0]    r_in0, r_in1;
  logic          w_unused;

  lizwiz_key_decode u_keys (
    .i_clk     (CLK),
    .i_reset   (RESET),
    .i_ps2_key (PS2_KEY),
    .o_keys    (w_keys)
  );

  always_comb begin
    w_up    = w_keys.up    | JOY1[JOY_UP];
    w_down  = w_keys.down  | JOY1[JOY_DOWN];
    w_left  = w_keys.left  | JOY1[JOY_LEFT];
    w_right = w_keys.right | JOY1[JOY_RIGHT];
    if (ROTATE) begin
      w_up    = w_keys.left  | JOY1[JOY_LEFT];
      w_down  = w_keys.right | JOY1[JOY_RIGHT];
      w_left  = w_keys.down  | JOY1[JOY_DOWN];
      w_right = w_keys.up    | JOY1[JOY_UP];
    end
  end

  assign w_fire   = w_keys.fire | JOY1[JOY_FIRE];
  assign w_start1 = w_keys.f1 | JOY1[JOY_START1] | JOY2[JOY_START1];
  assign w_start2 = w_keys.f2 | JOY1[JOY_START2] | JOY2[JOY_START2];
  assign w_src    = w_start1 | w_start2 | w_keys.f3;
  assign w_joy_src = JOY1[JOY_START1] | JOY2[JOY_START1]
                   | JOY1[JOY_START2] | JOY2[JOY_START2];
  assign w_req    = w_src & ~r_src;
  assign w_frame  = VBLANK & ~r_vb;
  assign w_coin   = (r_state == COIN_PULSE);
  assign w_unused = ^{JOY1[15:7], JOY2[15:7]};

  always_comb begin
    w_state = r_state;
    w_fcnt  = r_fcnt;
    w_pend  = r_pend;
    w_cnt   = r_cnt;
    unique case (r_state)
      COIN_IDLE: begin
        if (w_req | r_pend) begin
          w_state = COIN_PULSE;
          w_pend  = 1'b0;
          w_cnt   = r_cnt + 8'd1;
          w_fcnt  = '0;
        end
      end
      COIN_PULSE: begin
        if (w_req) w_pend = 1'b1;
        if (w_frame) begin
          if (r_fcnt == CW'(COIN_FRAMES - 1)) begin
            w_state = COIN_HOLDOFF;
            w_fcnt  = '0;
          end else begin
            w_fcnt = r_fcnt + CW'(1);
          end
        end
      end
      COIN_HOLDOFF: begin
        if (w_req) w_pend = 1'b1;
        if (w_frame) begin
          if (r_fcnt == CW'(HOLDOFF_FRAMES - 1)) begin
            w_state = COIN_IDLE;
          end else begin
            w_fcnt = r_fcnt + CW'(1);
          end
        end
      end
      default: w_state = COIN_IDLE;
    endcase
  end

  always_comb begin
    w_in0 = '0;
    w_in0[IN0_UP]    = w_up;
    w_in0[IN0_LEFT]  = w_left;
    w_in0[IN0_RIGHT] = w_right;
    w_in0[IN0_DOWN]  = w_down;
    w_in0[IN0_COIN]  = w_coin;
    w_in1 = '0;
    w_in1[IN1_J2UP]    = JOY2[JOY_UP];
    w_in1[IN1_J2LEFT]  = JOY2[JOY_LEFT];
    w_in1[IN1_J2RIGHT] = JOY2[JOY_RIGHT];
    w_in1[IN1_J2DOWN]  = JOY2[JOY_DOWN];
    w_in1[IN1_FIRE]    = w_fire;
    w_in1[IN1_START1]  = w_start1;
    w_in1[IN1_START2]  = w_start2;
    w_in1[IN1_J2FIRE]  = JOY2[JOY_FIRE];
  end

  // Edge history loads current levels so held inputs stay quiet.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= COIN_IDLE;
      r_fcnt  <= '0;
      r_pend  <= 1'b0;
      r_cnt   <= 8'd0;
      r_in0   <= 8'hFF;
      r_in1   <= 8'hFF;
      r_src   <= w_joy_src;
      r_vb    <= VBLANK;
    end else begin
      r_state <= w_state;
      r_fcnt  <= w_fcnt;
      r_pend  <= w_pend;
      r_cnt   <= w_cnt;
      r_in0   <= ~w_in0;
      r_in1   <= ~w_in1;
      r_src   <= w_src;
      r_vb    <= VBLANK;
    end
  end

  assign IN0        = r_in0;
  assign IN1        = r_in1;
  assign COIN_COUNT = r_cnt;

endmodule

// File: tb/tb_lizwiz_input_ctrl.sv
// Scoreboard bench for lizwiz_input_ctrl: every output change is
// popped against a queue of hand-computed expected port values.
module tb_lizwiz_input_ctrl;

  logic        CLK;
  logic        RESET;
  logic [64:0] PS2_KEY;
  logic [15:0] JOY1, JOY2;
  logic        ROTATE, VBLANK;
  logic [7:0]  IN0, IN1, COIN_COUNT;

  lizwiz_input_ctrl #(
    .COIN_FRAMES    (4),
    .HOLDOFF_FRAMES (8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PS2_KEY    (PS2_KEY),
    .JOY1       (JOY1),
    .JOY2       (JOY2),
    .ROTATE     (ROTATE),
    .VBLANK     (VBLANK),
    .IN0        (IN0),
    .IN1        (IN1),
    .COIN_COUNT (COIN_COUNT)
  );

  typedef struct {
    string      nm;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] cnt;
    int         fr;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          fcnt = 0;
  logic        done = 1'b0;
  logic        flushed = 1'b0;
  logic [23:0] last = '0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, required end by 200000");
    $fatal(1, "watchdog");
  end

  always @(negedge CLK) begin
    exp_t e;
    logic [23:0] cur;
    cur = {IN0, IN1, COIN_COUNT};
    if (cur !== last) begin
      last = cur;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected: got %h/%h/%h frame %0d, required no change",
                 IN0, IN1, COIN_COUNT, fcnt);
      end else begin
        e = q.pop_front();
        if (IN0 !== e.in0 || IN1 !== e.in1 || COIN_COUNT !== e.cnt
            || (e.fr >= 0 && e.fr != fcnt)) begin
          n_bad++;
          $display("FAIL %s: got %h/%h/%h frame %0d, required %h/%h/%h frame %0d",
                   e.nm, IN0, IN1, COIN_COUNT, fcnt,
                   e.in0, e.in1, e.cnt, e.fr);
        end
      end
    end
    if (done && !flushed) begin
      flushed = 1'b1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no output change, required %h/%h/%h",
                 e.nm, e.in0, e.in1, e.cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic px(input string nm, input logic [7:0] a,
                    input logic [7:0] b, input logic [7:0] c,
                    input int fr);
    exp_t e;
    e.nm = nm; e.in0 = a; e.in1 = b; e.cnt = c; e.fr = fr;
    q.push_back(e);
  endtask

  task automatic key(input logic [7:0] b2, input logic [7:0] b1,
                     input logic [7:0] code, input logic [39:0] hi);
    PS2_KEY = {~PS2_KEY[64], hi, b2, b1, code};
  endtask

  task automatic frame();
    VBLANK = 1'b1;
    fcnt++;
    tick(2);
    VBLANK = 1'b0;
    tick(3);
  endtask

  initial begin
    int b;
    RESET = 1'b1; PS2_KEY = '0; JOY1 = '0; JOY2 = '0;
    ROTATE = 1'b0; VBLANK = 1'b0;
    px("reset", 8'hFF, 8'hFF, 8'h00, -1);
    tick(3); RESET = 1'b0; tick(3);

    px("up_press", 8'hFE, 8'hFF, 8'h00, -1);
    key(8'h00, 8'h00, 8'h75, 40'd0); tick(3);
    px("up_rel_ext", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'hE0, 8'hF0, 8'h75, 40'd0); tick(3);
    px("right_ext", 8'hFB, 8'hFF, 8'h00, -1);
    key(8'h00, 8'hE0, 8'h74, 40'd0); tick(3);
    px("right_rel", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'hE0, 8'hF0, 8'h74, 40'd0); tick(3);
    px("down_press", 8'hF7, 8'hFF, 8'h00, -1);
    key(8'h00, 8'h00, 8'h72, 40'd0); tick(3);
    px("down_rel", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'h00, 8'hF0, 8'h72, 40'd0); tick(3);
    px("space", 8'hFF, 8'hEF, 8'h00, -1);
    key(8'h00, 8'h00, 8'h29, 40'd0); tick(3);
    px("space_rel", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'h00, 8'hF0, 8'h29, 40'd0); tick(3);
    px("ctrl", 8'hFF, 8'hEF, 8'h00, -1);
    key(8'h00, 8'h00, 8'h14, 40'd0); tick(3);
    px("ctrl_rel", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'h00, 8'hF0, 8'h14, 40'd0); tick(3);
    key(8'h00, 8'h00, 8'h1C, 40'd0); tick(3);
    key(8'h00, 8'h00, 8'h75, 40'd1); tick(3);
    px("left_after_filter", 8'hFD, 8'hFF, 8'h00, -1);
    key(8'h00, 8'h00, 8'h6B, 40'd0); tick(3);
    px("left_rel", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'h00, 8'hF0, 8'h6B, 40'd0); tick(3);

    ROTATE = 1'b1;
    px("rot_joyleft", 8'hFE, 8'hFF, 8'h00, -1);
    JOY1 = 16'h0002; tick(3);
    px("rot_joy_off", 8'hFF, 8'hFF, 8'h00, -1);
    JOY1 = 16'h0000; tick(3);
    px("rot_keyup", 8'hFB, 8'hFF, 8'h00, -1);
    key(8'h00, 8'h00, 8'h75, 40'd0); tick(3);
    px("rot_keyup_rel", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'h00, 8'hF0, 8'h75, 40'd0); tick(3);
    ROTATE = 1'b0; tick(2);

    px("key_and_joy", 8'hF7, 8'hEF, 8'h00, -1);
    key(8'h00, 8'h00, 8'h72, 40'd0); JOY1 = 16'h0010; tick(3);
    px("key_and_joy_rel", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'h00, 8'hF0, 8'h72, 40'd0); JOY1 = 16'h0000; tick(3);
    px("joy2", 8'hFF, 8'h7B, 8'h00, -1);
    JOY2 = 16'h0011; tick(3);
    px("joy2_off", 8'hFF, 8'hFF, 8'h00, -1);
    JOY2 = 16'h0000; tick(3);

    px("start1_joy", 8'hFF, 8'hDF, 8'h01, -1);
    px("coin1_on", 8'hDF, 8'hDF, 8'h01, fcnt);
    JOY1 = 16'h0020; tick(3);
    px("start1_off", 8'hDF, 8'hFF, 8'h01, -1);
    JOY1 = 16'h0000; tick(2);
    px("coin1_off", 8'hFF, 8'hFF, 8'h01, fcnt + 4);
    repeat (12) frame();
    tick(3);

    b = fcnt;
    px("f1_press", 8'hFF, 8'hDF, 8'h02, -1);
    px("coin2_on", 8'hDF, 8'hDF, 8'h02, b);
    key(8'h00, 8'h00, 8'h05, 40'd0); tick(3);
    px("f1_rel", 8'hDF, 8'hFF, 8'h02, -1);
    key(8'h00, 8'hF0, 8'h05, 40'd0); tick(3);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) key(8'h00, 8'h00, 8'h04, 40'd0);
      if (i == 3) px("coin2_off", 8'hFF, 8'hFF, 8'h02, b + 4);
      frame();
      if (i == 0) begin
        key(8'h00, 8'hF0, 8'h04, 40'd0); tick(2);
      end
      if (i == 1) begin
        px("j2start", 8'hDF, 8'hDF, 8'h02, -1);
        JOY2 = 16'h0020; tick(3);
        px("j2start_off", 8'hDF, 8'hFF, 8'h02, -1);
        JOY2 = 16'h0000; tick(3);
      end
    end
    px("pend_cnt", 8'hFF, 8'hFF, 8'h03, b + 12);
    px("coin3_on", 8'hDF, 8'hFF, 8'h03, b + 12);
    px("coin3_off", 8'hFF, 8'hFF, 8'h03, b + 16);
    repeat (20) frame();
    tick(3);

    px("start_pre_rst", 8'hFF, 8'hDF, 8'h04, -1);
    px("coin4_on", 8'hDF, 8'hDF, 8'h04, fcnt);
    JOY1 = 16'h0020; tick(4);
    px("reset_mid_pulse", 8'hFF, 8'hFF, 8'h00, -1);
    RESET = 1'b1; VBLANK = 1'b1;
    key(8'h00, 8'h00, 8'h75, 40'd0); tick(3);
    px("held_start", 8'hFF, 8'hDF, 8'h00, -1);
    RESET = 1'b0; tick(4);
    px("held_start_off", 8'hFF, 8'hFF, 8'h00, -1);
    VBLANK = 1'b0; JOY1 = 16'h0000; tick(3);
    px("left_post_rst", 8'hFD, 8'hFF, 8'h00, -1);
    key(8'h00, 8'h00, 8'h6B, 40'd0); tick(3);
    px("left_post_rel", 8'hFF, 8'hFF, 8'h00, -1);
    key(8'h00, 8'hF0, 8'h6B, 40'd0); tick(5);

    done = 1'b1;
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
